parity_link_controller: RTL and testbench

Sequencer for a parity-protected 4-bit word link. It accepts words on a valid/ready input, generates an even-parity frame, and passes it through a noise-injection channel. It checks the received frame and retransmits on a detected error, up to a retry limit. It sits between a word producer and consumer as the controlling wrapper around the parity generate/inject/check datapath, with optional error statistics.

---
 rtl/parity_link_pkg.sv | 22 ++
 rtl/parity_link_channel.sv | 32 +++
 rtl/parity_link_controller.sv | 124 ++++++++++++
 tb/tb_parity_link_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_link_pkg.sv
// Shared types and helpers for the parity-protected word link controller.
package parity_link_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_XMIT,
    S_CHECK,
    S_OUT
  } state_t;

  localparam logic [2:0] NOISE_NONE   = 3'd0;
  localparam logic [2:0] NOISE_DOUBLE = 3'd6;

  localparam int PAR_MAX_W = 32;

  // Even-parity bit: XOR of all bits, so data plus this bit has an even count of ones.
  function automatic logic parity_even(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_link_channel.sv
// Noise-injection channel: corrupts a parity frame according to a 3-bit noise
// code and reports the receive-side parity syndrome. Purely combinational.
module parity_link_channel
  import parity_link_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W:0] frame,
  input  logic [2:0]      noise,
  output logic [DATA_W:0] rx_frame,
  output logic            syndrome
);

  logic [DATA_W:0] mask;

  always_comb begin
    // NOTE: assigning a default before the case keeps unlisted codes from inferring a latch.
    mask = '0;
    case (noise)
      NOISE_NONE:                 mask = '0;
      3'd1, 3'd2, 3'd3, 3'd4:     mask[noise - 3'd1] = 1'b1;
      3'd5:                       mask[DATA_W] = 1'b1;
      // Two flipped bits keep parity even, so the checker cannot see this one.
      NOISE_DOUBLE:               mask[1:0] = 2'b11;
      default:                    mask = '0;
    endcase
  end

  assign rx_frame = frame ^ mask;
  assign syndrome = parity_even(PAR_MAX_W'(rx_frame));

endmodule

// File: rtl/parity_link_controller.sv
// Sequencer for a parity-protected word link with retransmission on detected errors.
// Error statistics are built only when PARITY_LINK_STATS_EN is defined.
module parity_link_controller
  import parity_link_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [2:0]        noise,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_fail,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  fail_cnt
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W:0]     tx_frame_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                syndrome_q;
  logic [RETRY_W-1:0]  retry_q;
  logic                out_fail_q;

  logic [DATA_W:0]     ch_rx_frame;
  logic                ch_syndrome;

  parity_link_channel #(.DATA_W(DATA_W)) u_channel (
    .frame    (tx_frame_q),
    .noise    (noise),
    .rx_frame (ch_rx_frame),
    .syndrome (ch_syndrome)
  );

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all state updates see pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      tx_frame_q <= '0;
      rx_data_q  <= '0;
      syndrome_q <= 1'b0;
      retry_q    <= '0;
      out_fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_valid) begin
          data_q     <= in_data;
          retry_q    <= '0;
          out_fail_q <= 1'b0;
        end
        S_GEN:  tx_frame_q <= {parity_even(PAR_MAX_W'(data_q)), data_q};
        S_XMIT: begin
          rx_data_q  <= ch_rx_frame[DATA_W-1:0];
          syndrome_q <= ch_syndrome;
        end
        S_CHECK: if (syndrome_q) begin
          if (retry_q < RETRY_MAX) retry_q <= retry_q + 1'b1;
          else                     out_fail_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == S_IDLE) && !rst;
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_OUT);
    out_fail  = out_fail_q;
    out_data  = rx_data_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_GEN;
      S_GEN:   state_d = S_XMIT;
      S_XMIT:  state_d = S_CHECK;
      S_CHECK: begin
        if (!syndrome_q)              state_d = S_OUT;
        else if (retry_q < RETRY_MAX) state_d = S_XMIT;
        else                          state_d = S_OUT;
      end
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PARITY_LINK_STATS_EN
  logic [CNT_W-1:0] err_q, fail_q;
  logic             err_inc, fail_inc;

  assign err_inc  = (state_q == S_CHECK) && syndrome_q;
  assign fail_inc = err_inc && (retry_q >= RETRY_MAX);

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= '0;
      fail_q <= '0;
    end else begin
      if (err_inc && (err_q != '1))   err_q  <= err_q + 1'b1;
      if (fail_inc && (fail_q != '1)) fail_q <= fail_q + 1'b1;
    end
  end

  assign err_cnt  = err_q;
  assign fail_cnt = fail_q;
`else
  assign err_cnt  = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_link_controller.sv
// Self-checking bench for parity_link_controller: directed cases plus randomized
// noise/handshake traffic scored against a per-word behavioural model.
module tb_parity_link_controller;

  localparam int DATA_W    = 4;
  localparam int MAX_RETRY = 3;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

`ifdef PARITY_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [2:0]        noise;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_fail;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  fail_cnt;

  int n_vec = 0;
  int n_err = 0;
  int err_model  = 0;
  int fail_model = 0;

  parity_link_controller #(
    .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .noise     (noise),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_fail  (out_fail),
    .out_ready (out_ready),
    .busy      (busy),
    .err_cnt   (err_cnt),
    .fail_cnt  (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W:0] noise_mask(input logic [2:0] c);
    if (c >= 3'd1 && c <= 3'd5) return (DATA_W+1)'(1) << (c - 3'd1);
    if (c == 3'd6)              return (DATA_W+1)'(3);
    return '0;
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_err_cnt"},  32'(err_cnt),  STATS ? 32'(err_model)  : 32'd0);
    check({tag, "_fail_cnt"}, 32'(fail_cnt), STATS ? 32'(fail_model) : 32'd0);
  endtask

  // One word end to end. Called and returning at a falling edge with the DUT idle.
  // mode 0: random noise, 1: noise held at fix, 2: fix on first attempt then clean.
  // dly: OUT cycles before out_ready is raised (>= 1).
  task automatic run_word(input logic [DATA_W-1:0] d, input int mode,
                          input logic [2:0] fix, input int dly);
    logic [2:0]      nz [16];
    logic [DATA_W:0] frame, rx;
    logic [DATA_W-1:0] exp_data;
    logic            exp_fail;
    int attempts, errs, o_edge, h_edge;

    for (int i = 0; i < 16; i++) begin
      case (mode)
        1:       nz[i] = fix;
        2:       nz[i] = (i == 2) ? fix : 3'd0;
        default: nz[i] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      endcase
    end

    // Attempt k samples noise on edge 2+2k after the accept edge.
    frame    = {1'($countones(d) % 2), d};
    errs     = 0;
    attempts = 0;
    exp_fail = 1'b0;
    exp_data = '0;
    for (int k = 0; k <= MAX_RETRY; k++) begin
      attempts++;
      rx       = frame ^ noise_mask(nz[2 + 2*k]);
      exp_data = rx[DATA_W-1:0];
      if ($countones(rx) % 2 == 0) break;
      errs++;
      if (k == MAX_RETRY) exp_fail = 1'b1;
    end
    err_model  = sat(err_model + errs);
    fail_model = sat(fail_model + (exp_fail ? 1 : 0));
    o_edge = 2*attempts + 1;
    h_edge = o_edge + dly;

    in_data   = d;
    in_valid  = 1'b1;
    noise     = 3'($urandom);
    out_ready = 1'($urandom_range(0, 1));
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);

    for (int n = 1; n <= h_edge; n++) begin
      @(negedge clk);
      // Stimulus for edge n; in_valid stays high with junk data to prove it is ignored.
      noise     = nz[n];
      in_valid  = 1'b1;
      in_data   = DATA_W'($urandom);
      if (n <= o_edge)     out_ready = 1'($urandom_range(0, 1));
      else if (n < h_edge) out_ready = 1'b0;
      else                 out_ready = 1'b1;
      // Checks for the state after edge n-1.
      if (n - 1 < o_edge) begin
        check("out_valid_early", 32'(out_valid), 32'd0);
      end else begin
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_data",  32'(out_data),  32'(exp_data));
        check("out_fail",  32'(out_fail),  32'(exp_fail));
        if (n - 1 == o_edge) check_counters("word");
      end
      check("in_ready_busy", 32'(in_ready), 32'd0);
      check("busy", 32'(busy), 32'd1);
    end

    @(negedge clk);
    check("out_valid_after", 32'(out_valid), 32'd0);
    check("in_ready_after",  32'(in_ready),  32'd1);
    check("busy_after",      32'(busy),      32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Accept a word, then pulse rst while it is in XMIT.
  task automatic reset_in_xmit(input logic [DATA_W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    noise    = 3'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_model  = 0;
    fail_model = 0;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_fail",  32'(out_fail),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check_counters("rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_busy",      32'(busy),      32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    noise     = 3'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_out_fail",  32'(out_fail),  32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd0);
    check_counters("reset");
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Directed cases: clean, single retry, abandoned word, undetected double error.
    run_word(4'b1010, 1, 3'd0, 1);
    run_word(4'b1111, 2, 3'd2, 1);
    run_word(4'b0110, 1, 3'd3, 1);
    run_word(4'b1011, 1, 3'd6, 1);
    // Consumer stalls three cycles in OUT while the producer keeps offering.
    run_word(4'b0101, 1, 3'd0, 4);
    run_word(4'b1100, 1, 3'd5, 4);

    for (int i = 0; i < 150; i++)
      run_word(DATA_W'($urandom), 0, 3'd0, int'($urandom_range(1, 3)));

    reset_in_xmit(4'b1001);
    run_word(4'b0011, 1, 3'd1, 1);

    // Push both counters past all-ones to exercise saturation.
    for (int i = 0; i < 260; i++)
      run_word(DATA_W'($urandom), 1, 3'd5, 1);
    check_counters("saturated");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
